lbls_test_pulse_generator: RTL and testbench

Transmit-side companion to the LBLS bank receiver: synthesizes 8-bit serializer words for 12 channels carrying programmable rectangular test pulses (bit-level delay and width, word-level period, finite or continuous repetition). Outputs feed the OSERDES lanes that loop back into the LBLS receive path, or feed the bank's `win` inputs directly in simulation. A `gate` output marks the words that contain a pulse, for use as the receiver's gate/trigger_active during calibration.

---
 rtl/lbls_test_pulse_generator_pkg.sv | 34 +++
 rtl/lbls_test_pulse_generator_pulse_window_word.sv | 34 +++
 rtl/lbls_test_pulse_generator.sv | 165 ++++++++++++++++
 tb/tb_lbls_test_pulse_generator.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/lbls_test_pulse_generator_pkg.sv
// Shared constants, state encoding and latched run configuration for the LBLS test pulse generator.
// Latency: none (types and constants only).
// Backpressure: none; the generator free-runs on the word clock.
package lbls_test_pulse_generator_pkg;

  // Serializer word size in bit-times; bit 7 leaves the OSERDES first.
  localparam int BIT_DEPTH          = 8;
  localparam int NUMBER_OF_CHANNELS = 12;
  // A pulse ends at most 255 + 255 bit-times after period start, so only the
  // first 64 words of a period can ever contain pulse bits.
  localparam int MAX_PULSE_WORDS    = 64;
  // Wide enough that delay + width and the bit time never wrap.
  localparam int TIME_WIDTH         = 11;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Per-run settings captured when a start is accepted.
  typedef struct packed {
    logic [NUMBER_OF_CHANNELS:1] channel_mask;
    logic [NUMBER_OF_CHANNELS:1] polarity_mask;
    logic [7:0]                  delay;
    logic [7:0]                  width;
  } pulse_cfg_t;

  // Exclusive end of the pulse window, in bit-times from period start.
  function automatic logic [TIME_WIDTH-1:0] pulse_end(input logic [7:0] delay,
                                                      input logic [7:0] width);
    return TIME_WIDTH'(delay) + TIME_WIDTH'(width);
  endfunction

endpackage

// File: rtl/lbls_test_pulse_generator_pulse_window_word.sv
// Maps a word index within the pulse period to the 8 bits that fall inside [delay, delay+width).
// Latency: purely combinational.
// Backpressure: none.
module pulse_window_word
  import lbls_test_pulse_generator_pkg::*;
#(
  parameter int PHASE_WIDTH = 24
) (
  input  logic [PHASE_WIDTH-1:0] phase,
  input  logic [7:0]             delay,
  input  logic [7:0]             width,
  output logic [BIT_DEPTH-1:0]   hitword
);

  localparam logic [PHASE_WIDTH-1:0] LAST_HIT_WORD = PHASE_WIDTH'(MAX_PULSE_WORDS);

  logic [TIME_WIDTH-1:0] window_end;

  assign window_end = pulse_end(delay, width);

  // Bit b of word w sits at time 8*w + (7-b); words past the reachable range never hit.
  always_comb begin : hit_calc
    logic [TIME_WIDTH-1:0] bit_time;
    hitword  = '0;
    bit_time = '0;
    if (phase < LAST_HIT_WORD) begin
      for (int b = 0; b < BIT_DEPTH; b++) begin
        bit_time   = {2'b00, phase[5:0], 3'(BIT_DEPTH - 1 - b)};
        hitword[b] = (bit_time >= TIME_WIDTH'(delay)) && (bit_time < window_end);
      end
    end
  end

endmodule

// File: rtl/lbls_test_pulse_generator.sv
// Generates programmable rectangular test pulses as 8-bit serializer words on 12 channels, with a gate marker.
// Latency: start at edge N -> busy after N, word 0 on wout after N+1 (one output register).
// Backpressure: none; words are produced every cycle, start is ignored while busy and abort wins over start.
module lbls_test_pulse_generator
  import lbls_test_pulse_generator_pkg::*;
#(
  parameter int PERIOD_WIDTH = 24,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          abort,
  input  logic [NUMBER_OF_CHANNELS:1]   channel_mask,
  input  logic [NUMBER_OF_CHANNELS:1]   polarity_mask,
  input  logic [7:0]                    delay,
  input  logic [7:0]                    width,
  input  logic [PERIOD_WIDTH-1:0]       period,
  input  logic [COUNT_WIDTH-1:0]        number_of_pulses,
  output logic [BIT_DEPTH-1:0]          wout1,
  output logic [BIT_DEPTH-1:0]          wout2,
  output logic [BIT_DEPTH-1:0]          wout3,
  output logic [BIT_DEPTH-1:0]          wout4,
  output logic [BIT_DEPTH-1:0]          wout5,
  output logic [BIT_DEPTH-1:0]          wout6,
  output logic [BIT_DEPTH-1:0]          wout7,
  output logic [BIT_DEPTH-1:0]          wout8,
  output logic [BIT_DEPTH-1:0]          wout9,
  output logic [BIT_DEPTH-1:0]          wout10,
  output logic [BIT_DEPTH-1:0]          wout11,
  output logic [BIT_DEPTH-1:0]          wout12,
  output logic                          gate,
  output logic                          busy,
  output logic                          done,
  output logic [COUNT_WIDTH-1:0]        pulse_count
);

  // A one-word period would leave no room to ever return to phase 0 distinctly.
  localparam logic [PERIOD_WIDTH-1:0] MIN_PERIOD = PERIOD_WIDTH'(2);
  localparam logic [PERIOD_WIDTH-1:0] PHASE_ONE  = PERIOD_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0]  COUNT_ONE  = COUNT_WIDTH'(1);

  state_t                   state_q;
  pulse_cfg_t               cfg_q;
  logic [PERIOD_WIDTH-1:0]  period_q;
  logic [PERIOD_WIDTH-1:0]  phase_q;
  logic [COUNT_WIDTH-1:0]   target_q;
  logic [COUNT_WIDTH-1:0]   pulse_count_q;
  logic                     busy_q;
  logic                     done_q;
  logic [BIT_DEPTH-1:0]     wout_q [1:NUMBER_OF_CHANNELS];
  logic                     gate_q;

  logic [PERIOD_WIDTH-1:0]  period_eff;
  logic                     phase_last;
  logic [COUNT_WIDTH-1:0]   count_next;
  logic                     run_complete;
  logic [BIT_DEPTH-1:0]     hitword;

  assign period_eff   = (period < MIN_PERIOD) ? MIN_PERIOD : period;
  assign phase_last   = (phase_q == (period_q - PHASE_ONE));
  assign count_next   = pulse_count_q + COUNT_ONE;
  // A zero target means run until aborted.
  assign run_complete = (target_q != '0) && (count_next == target_q);

  // Delay and width are global, so one window decoder serves every channel.
  pulse_window_word #(
    .PHASE_WIDTH (PERIOD_WIDTH)
  ) u_pulse_window_word (
    .phase   (phase_q),
    .delay   (cfg_q.delay),
    .width   (cfg_q.width),
    .hitword (hitword)
  );

  // Run control: accept start, step the phase, count periods, finish or abort.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      cfg_q         <= '0;
      period_q      <= MIN_PERIOD;
      phase_q       <= '0;
      target_q      <= '0;
      pulse_count_q <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && !abort) begin
            state_q             <= RUN;
            busy_q              <= 1'b1;
            cfg_q.channel_mask  <= channel_mask;
            cfg_q.polarity_mask <= polarity_mask;
            cfg_q.delay         <= delay;
            cfg_q.width         <= width;
            period_q            <= period_eff;
            target_q            <= number_of_pulses;
            phase_q             <= '0;
            pulse_count_q       <= '0;
          end
        end
        RUN: begin
          if (abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (phase_last) begin
            phase_q       <= '0;
            pulse_count_q <= count_next;
            if (run_complete) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end else begin
            phase_q <= phase_q + PHASE_ONE;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Output register: masked/inverted pulse words while running, live idle level otherwise.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 1; i <= NUMBER_OF_CHANNELS; i++) begin
        wout_q[i] <= '0;
      end
      gate_q <= 1'b0;
    end else begin
      for (int i = 1; i <= NUMBER_OF_CHANNELS; i++) begin
        if (state_q == RUN) begin
          wout_q[i] <= (hitword & {BIT_DEPTH{cfg_q.channel_mask[i]}})
                       ^ {BIT_DEPTH{cfg_q.polarity_mask[i]}};
        end else begin
          wout_q[i] <= {BIT_DEPTH{polarity_mask[i]}};
        end
      end
      gate_q <= (state_q == RUN) && (|hitword);
    end
  end

  assign wout1       = wout_q[1];
  assign wout2       = wout_q[2];
  assign wout3       = wout_q[3];
  assign wout4       = wout_q[4];
  assign wout5       = wout_q[5];
  assign wout6       = wout_q[6];
  assign wout7       = wout_q[7];
  assign wout8       = wout_q[8];
  assign wout9       = wout_q[9];
  assign wout10      = wout_q[10];
  assign wout11      = wout_q[11];
  assign wout12      = wout_q[12];
  assign gate        = gate_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pulse_count = pulse_count_q;

endmodule

// File: tb/tb_lbls_test_pulse_generator.sv
// Directed bench for lbls_test_pulse_generator with hand-computed expected words.
// Latency: outputs sampled 1 time unit after each rising clock edge.
// Backpressure: none; inputs are driven right after the sample point.
module tb_lbls_test_pulse_generator;

  localparam int PW = 24;
  localparam int CW = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [12:1]   channel_mask = '0;
  logic [12:1]   polarity_mask = '0;
  logic [7:0]    delay = '0;
  logic [7:0]    width = '0;
  logic [PW-1:0] period = '0;
  logic [CW-1:0] number_of_pulses = '0;
  logic [7:0]    wout [1:12];
  logic          gate;
  logic          busy;
  logic          done;
  logic [CW-1:0] pulse_count;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_straddle [4] = '{8'h1f, 8'hf8, 8'h00, 8'h00};

  always #5 clock = ~clock;

  lbls_test_pulse_generator #(
    .PERIOD_WIDTH (PW),
    .COUNT_WIDTH  (CW)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .start            (start),
    .abort            (abort),
    .channel_mask     (channel_mask),
    .polarity_mask    (polarity_mask),
    .delay            (delay),
    .width            (width),
    .period           (period),
    .number_of_pulses (number_of_pulses),
    .wout1            (wout[1]),
    .wout2            (wout[2]),
    .wout3            (wout[3]),
    .wout4            (wout[4]),
    .wout5            (wout[5]),
    .wout6            (wout[6]),
    .wout7            (wout[7]),
    .wout8            (wout[8]),
    .wout9            (wout[9]),
    .wout10           (wout[10]),
    .wout11           (wout[11]),
    .wout12           (wout[12]),
    .gate             (gate),
    .busy             (busy),
    .done             (done),
    .pulse_count      (pulse_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic launch(input logic [12:1] cm, input logic [12:1] pm, input logic [7:0] d,
                        input logic [7:0] w, input int per, input int n);
    channel_mask     = cm;
    polarity_mask    = pm;
    delay            = d;
    width            = w;
    period           = PW'(per);
    number_of_pulses = CW'(n);
    start            = 1'b1;
    tick();
    start            = 1'b0;
  endtask

  initial begin
    // Reset state
    #2 reset = 1'b0;
    #1;
    for (int i = 1; i <= 12; i++) check_eq($sformatf("rst_wout%0d", i), wout[i], 8'h00);
    check_eq("rst_gate", gate, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_pcount", pulse_count, 16'd0);
    #10 reset = 1'b1;
    tick();
    tick();

    // Basic run: ch1, delay 0, width 8, period 4, 3 pulses
    launch(12'h001, 12'h000, 8'd0, 8'd8, 4, 3);
    check_eq("basic_busy_start", busy, 1'b1);
    for (int k = 0; k < 12; k++) begin
      tick();
      check_eq($sformatf("basic_w1_%0d", k), wout[1], (k % 4 == 0) ? 8'hff : 8'h00);
      check_eq($sformatf("basic_w2_%0d", k), wout[2], 8'h00);
      check_eq($sformatf("basic_gate_%0d", k), gate, (k % 4 == 0));
      check_eq($sformatf("basic_done_%0d", k), done, (k == 11));
      check_eq($sformatf("basic_busy_%0d", k), busy, (k != 11));
      if (k == 4) check_eq("basic_pcount_mid", pulse_count, 16'd1);
    end
    check_eq("basic_pcount", pulse_count, 16'd3);
    tick();
    check_eq("basic_idle_w1", wout[1], 8'h00);
    check_eq("basic_done_clr", done, 1'b0);

    // Word straddling: delay 3, width 10
    launch(12'h001, 12'h000, 8'd3, 8'd10, 4, 1);
    for (int k = 0; k < 4; k++) begin
      tick();
      check_eq($sformatf("strad_w1_%0d", k), wout[1], exp_straddle[k]);
      check_eq($sformatf("strad_gate_%0d", k), gate, (k < 2));
    end
    check_eq("strad_done", done, 1'b1);

    // Inversion on channel 2
    polarity_mask = 12'h002;
    tick();
    tick();
    check_eq("inv_idle_w2", wout[2], 8'hff);
    launch(12'h002, 12'h002, 8'd0, 8'd8, 4, 1);
    for (int k = 0; k < 4; k++) begin
      tick();
      check_eq($sformatf("inv_w2_%0d", k), wout[2], (k == 0) ? 8'h00 : 8'hff);
      check_eq($sformatf("inv_w1_%0d", k), wout[1], 8'h00);
    end
    check_eq("inv_done", done, 1'b1);
    tick();
    check_eq("inv_idle_after", wout[2], 8'hff);
    polarity_mask = 12'h000;
    tick();

    // Continuous run, abort after 10 words (pulse sits in word 2)
    launch(12'h001, 12'h000, 8'd16, 8'd8, 4, 0);
    for (int k = 0; k < 10; k++) begin
      tick();
      check_eq($sformatf("cont_w1_%0d", k), wout[1], (k % 4 == 2) ? 8'hff : 8'h00);
      check_eq($sformatf("cont_done_%0d", k), done, 1'b0);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("abort_busy", busy, 1'b0);
    check_eq("abort_done", done, 1'b0);
    check_eq("abort_pcount", pulse_count, 16'd2);
    check_eq("abort_last_word", wout[1], 8'hff);
    tick();
    check_eq("abort_idle_w1", wout[1], 8'h00);
    check_eq("abort_done2", done, 1'b0);
    check_eq("abort_pcount_hold", pulse_count, 16'd2);

    // Second start while busy is ignored
    launch(12'h001, 12'h000, 8'd0, 8'd8, 4, 3);
    for (int k = 0; k < 12; k++) begin
      if (k == 5) start = 1'b1;
      tick();
      start = 1'b0;
      check_eq($sformatf("restart_w1_%0d", k), wout[1], (k % 4 == 0) ? 8'hff : 8'h00);
      check_eq($sformatf("restart_done_%0d", k), done, (k == 11));
    end
    check_eq("restart_pcount", pulse_count, 16'd3);

    // Start and abort together in IDLE: abort wins
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check_eq("startabort_busy", busy, 1'b0);
    check_eq("startabort_pcount", pulse_count, 16'd3);
    tick();
    check_eq("startabort_busy2", busy, 1'b0);
    check_eq("startabort_w1", wout[1], 8'h00);

    // Reset mid-run
    launch(12'h001, 12'h000, 8'd0, 8'd8, 4, 0);
    for (int k = 0; k < 5; k++) tick();
    check_eq("midrst_pre_w1", wout[1], 8'hff);
    check_eq("midrst_pre_pcount", pulse_count, 16'd1);
    reset = 1'b0;
    #1;
    check_eq("midrst_w1", wout[1], 8'h00);
    check_eq("midrst_busy", busy, 1'b0);
    check_eq("midrst_gate", gate, 1'b0);
    check_eq("midrst_pcount", pulse_count, 16'd0);
    @(negedge clock);
    reset = 1'b1;
    tick();
    check_eq("midrst_after_busy", busy, 1'b0);
    check_eq("midrst_after_w1", wout[1], 8'h00);

    // Degenerate: width 0, period 1 (effective 2), 2 pulses
    launch(12'h001, 12'h000, 8'd0, 8'd0, 1, 2);
    for (int k = 0; k < 4; k++) begin
      tick();
      check_eq($sformatf("degen_w1_%0d", k), wout[1], 8'h00);
      check_eq($sformatf("degen_gate_%0d", k), gate, 1'b0);
      check_eq($sformatf("degen_done_%0d", k), done, (k == 3));
    end
    check_eq("degen_pcount", pulse_count, 16'd2);
    check_eq("degen_busy", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
